// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues PC requests to imem, tracks in-flight/stale responses, buffers instructions for decode.
// Optional misaligned-PC handling is enabled by defining FETCH_MISALIGN_CHK_EN.
module if_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc,
    input  logic [31:0] pc_nxt,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_nxt,
    output logic [31:0] id_instr,
    output logic        id_misalign,
    output logic        err_spurious
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [PW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic          err_q, err_d;

    logic [31:0] pend_pc_q  [DEPTH];
    logic [31:0] pend_nxt_q [DEPTH];
    logic [31:0] out_pc_q    [DEPTH];
    logic [31:0] out_nxt_q   [DEPTH];
    logic [31:0] out_instr_q [DEPTH];

    logic [CW:0] occupancy;
    logic        space, issue_ok, mis_acc, grant;
    logic        rsp_any, rsp_drop, rsp_take, spurious;
    logic        out_push, out_pop;
    logic [31:0] push_pc, push_nxt, push_instr;

    // Every granted request reserves an output slot, so the output FIFO cannot overflow.
    assign occupancy = {1'b0, count_q} + {1'b0, live_q} + {1'b0, drop_q};
    assign space     = occupancy < DEPTH_C;
    assign issue_ok  = pc_valid & space & ~flush & ~rst;

`ifdef FETCH_MISALIGN_CHK_EN
    logic             pc_mis;
    logic             push_mis;
    logic [DEPTH-1:0] out_mis_q;

    // A misaligned PC waits for live requests to drain so it stays in program order.
    assign pc_mis   = pc[1:0] != 2'b00;
    assign mis_acc  = issue_ok & pc_mis & (live_q == '0);
    assign imem_req = issue_ok & ~pc_mis;
    assign push_pc    = mis_acc ? pc     : pend_pc_q[pend_rd_q];
    assign push_nxt   = mis_acc ? pc_nxt : pend_nxt_q[pend_rd_q];
    assign push_instr = mis_acc ? 32'h0000_0013 : imem_rdata;
    assign push_mis   = mis_acc;

    always_ff @(posedge clk) begin
        if (out_push) out_mis_q[out_wr_q] <= push_mis;
    end

    assign id_misalign = id_valid & out_mis_q[out_rd_q];
`else
    assign mis_acc    = 1'b0;
    assign imem_req   = issue_ok;
    assign push_pc    = pend_pc_q[pend_rd_q];
    assign push_nxt   = pend_nxt_q[pend_rd_q];
    assign push_instr = imem_rdata;
    assign id_misalign = 1'b0;
`endif

    assign grant     = imem_req & imem_gnt;
    assign pc_ready  = grant | mis_acc;
    assign imem_addr = pc & 32'hFFFF_FFFC;

    assign rsp_any  = imem_rvalid & ((drop_q != '0) | (live_q != '0));
    assign rsp_drop = imem_rvalid & (drop_q != '0);
    assign rsp_take = imem_rvalid & (drop_q == '0) & (live_q != '0);
    assign spurious = imem_rvalid & (drop_q == '0) & (live_q == '0);

    assign out_push = (rsp_take | mis_acc) & ~flush;
    assign out_pop  = id_valid & id_ready;

    assign id_valid     = count_q != '0;
    assign id_pc        = id_valid ? out_pc_q[out_rd_q]    : 32'h0;
    assign id_pc_nxt    = id_valid ? out_nxt_q[out_rd_q]   : 32'h0;
    assign id_instr     = id_valid ? out_instr_q[out_rd_q] : 32'h0;
    assign err_spurious = err_q;

    always_comb begin
        count_d   = count_q;
        live_d    = live_q;
        drop_d    = drop_q;
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        err_d     = err_q | spurious;
        if (flush) begin
            // In-flight requests become stale; a response arriving now retires one of them.
            count_d   = '0;
            live_d    = '0;
            drop_d    = drop_q + live_q - CW'(rsp_any);
            pend_wr_d = '0;
            pend_rd_d = '0;
            out_wr_d  = '0;
            out_rd_d  = '0;
        end else begin
            count_d = count_q + CW'(out_push) - CW'(out_pop);
            live_d  = live_q + CW'(grant) - CW'(rsp_take);
            drop_d  = drop_q - CW'(rsp_drop);
            if (grant)    pend_wr_d = pend_wr_q + PW'(1);
            if (rsp_take) pend_rd_d = pend_rd_q + PW'(1);
            if (out_push) out_wr_d  = out_wr_q + PW'(1);
            if (out_pop)  out_rd_d  = out_rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            live_q    <= '0;
            drop_q    <= '0;
            pend_wr_q <= '0;
            pend_rd_q <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            live_q    <= live_d;
            drop_q    <= drop_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            pend_pc_q[pend_wr_q]  <= pc;
            pend_nxt_q[pend_wr_q] <= pc_nxt;
        end
        if (out_push) begin
            out_pc_q[out_wr_q]    <= push_pc;
            out_nxt_q[out_wr_q]   <= push_nxt;
            out_instr_q[out_wr_q] <= push_instr;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=2): latency, back-pressure, flush/drop, spurious responses, reset.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc, pc_nxt;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_pc_nxt, id_instr;
    logic        id_misalign, err_spurious;

    int tests = 0;
    int fails = 0;
    int grants;

    if_fetch_queue #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .pc_valid(pc_valid), .pc(pc), .pc_nxt(pc_nxt), .pc_ready(pc_ready),
        .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_pc_nxt(id_pc_nxt), .id_instr(id_instr),
        .id_misalign(id_misalign), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc_valid = 1'b1; pc = 32'h100; pc_nxt = 32'h104; flush = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_ready", pc_ready, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_err", err_spurious, 0);

        // Single fetch: grant, response one cycle later, decode sees it the cycle after.
        rst = 1'b0;
        #1;
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h100);
        chk("t1_ready", pc_ready, 1);
        tick();
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        chk("t1_lat_valid", id_valid, 0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t1_valid", id_valid, 1);
        chk("t1_pc", id_pc, 32'h100);
        chk("t1_pc_nxt", id_pc_nxt, 32'h104);
        chk("t1_instr", id_instr, 32'h0050_0093);
        chk("t1_mis", id_misalign, 0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        chk("t1_popped", id_valid, 0);

        // Back-pressure: decode stalled, only DEPTH grants.
        pc_valid = 1'b1; pc = 32'h200; pc_nxt = 32'h204; imem_gnt = 1'b1;
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            grants += int'(pc_ready);
            tick();
        end
        chk("t2_grants", grants, 2);
        #1;
        chk("t2_stall", pc_ready, 0);
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA1;
        tick();
        imem_rdata = 32'hA2;
        tick();
        imem_rvalid = 1'b0;
        pc_valid = 1'b1; imem_gnt = 1'b1; pc = 32'h300; pc_nxt = 32'h304;
        #1;
        chk("t2_head", id_instr, 32'hA1);
        chk("t2_full", pc_ready, 0);
        id_ready = 1'b1;
        #1;
        chk("t2_full_pop", pc_ready, 0);
        tick();
        id_ready = 1'b0;
        #1;
        chk("t2_head2", id_instr, 32'hA2);
        chk("t2_resume", pc_ready, 1);
        tick();

        // Full queue: pop and response in the same cycle.
        pc_valid = 1'b0; imem_gnt = 1'b0; id_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hB3;
        #1;
        chk("t39_head", id_instr, 32'hA2);
        tick();
        id_ready = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("t39_valid", id_valid, 1);
        chk("t39_pc", id_pc, 32'h300);
        chk("t39_pc_nxt", id_pc_nxt, 32'h304);
        chk("t39_instr", id_instr, 32'hB3);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        chk("t39_empty", id_valid, 0);

        // Flush with two requests in flight; their responses must be dropped.
        pc_valid = 1'b1; imem_gnt = 1'b1; pc = 32'h200; pc_nxt = 32'h204;
        tick();
        pc = 32'h204; pc_nxt = 32'h208;
        tick();
        flush = 1'b1; pc = 32'h400; pc_nxt = 32'h404;
        #1;
        chk("t3_flush_req", imem_req, 0);
        chk("t3_flush_ready", pc_ready, 0);
        tick();
        flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001;
        #1;
        chk("t3_drop_block", imem_req, 0);
        tick();
        imem_rdata = 32'hDEAD_0002;
        #1;
        chk("t3_new_grant", pc_ready, 1);
        chk("t3_no_stale", id_valid, 0);
        tick();
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rdata = 32'h00A0_0113;
        #1;
        chk("t3_no_stale2", id_valid, 0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t3_valid", id_valid, 1);
        chk("t3_pc", id_pc, 32'h400);
        chk("t3_instr", id_instr, 32'h00A0_0113);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        chk("t3_empty", id_valid, 0);
        chk("t3_err_clean", err_spurious, 0);

`ifdef FETCH_MISALIGN_CHK_EN
        pc_valid = 1'b1; imem_gnt = 1'b1; pc = 32'h102; pc_nxt = 32'h106;
        #1;
        chk("mis_req", imem_req, 0);
        chk("mis_ready", pc_ready, 1);
        tick();
        pc_valid = 1'b0; imem_gnt = 1'b0;
        #1;
        chk("mis_valid", id_valid, 1);
        chk("mis_pc", id_pc, 32'h102);
        chk("mis_instr", id_instr, 32'h13);
        chk("mis_flag", id_misalign, 1);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
`endif

        // Spurious response with nothing outstanding.
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t4_err", err_spurious, 1);
        chk("t4_no_valid", id_valid, 0);

        // Reset mid-operation: the late response is spurious.
        pc_valid = 1'b1; imem_gnt = 1'b1; pc = 32'h500; pc_nxt = 32'h504;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_err", err_spurious, 0);
        chk("t5_rst_req", imem_req, 0);
        tick();
        rst = 1'b0; pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t5_late_err", err_spurious, 1);
        chk("t5_late_valid", id_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
